sram_clr: RTL and testbench



---
 rtl/sram_clr.sv | 138 +++++++++++++
 tb/tb_sram_clr.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sram_clr.sv
// Single-port synchronous SRAM with registered read data, a read-valid strobe
// and a clear engine that zeroes the array after reset and on request.
// Optional build macro: SRAM_CLR_WRITE_FIRST_EN (write-first read-during-write).
module sram_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic              busy_r;

    logic              access_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] rd_data_s;

    // Accept an access only in IDLE; a clear request wins over the access.
    always_comb begin
        access_s = 1'b0;
        if ((state_r == ST_IDLE) && !clr && en) begin
            access_s = 1'b1;
        end else begin
            access_s = 1'b0;
        end
    end

    // Single write port: clear walk in CLEAR, user write in IDLE.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = addr;
        mem_wdata_s = din;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_ptr_r;
            mem_wdata_s = {DATA_W{1'b0}};
        end else if (access_s && we) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Data captured into dout for an accepted access (read-during-write rule).
    always_comb begin
        rd_data_s = mem_r[addr];
`ifdef SRAM_CLR_WRITE_FIRST_EN
        if (we) begin
            rd_data_s = din;
        end else begin
            rd_data_s = mem_r[addr];
        end
`else
        rd_data_s = mem_r[addr];
`endif
    end

    // Storage array; intentionally not reset, the clear walk zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered dout, dout_valid and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_CLEAR;
            clr_ptr_r    <= {ADDR_W{1'b0}};
            dout_r       <= {DATA_W{1'b0}};
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    dout_valid_r <= 1'b0;
                    if (clr_ptr_r == LAST_ADDR) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end else begin
                        clr_ptr_r <= clr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_r      <= ST_CLEAR;
                        clr_ptr_r    <= {ADDR_W{1'b0}};
                        busy_r       <= 1'b1;
                        dout_valid_r <= 1'b0;
                    end else if (access_s) begin
                        dout_r       <= rd_data_s;
                        dout_valid_r <= 1'b1;
                    end else begin
                        dout_valid_r <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover by re-running the clear walk.
                    state_r      <= ST_CLEAR;
                    clr_ptr_r    <= {ADDR_W{1'b0}};
                    dout_valid_r <= 1'b0;
                    busy_r       <= 1'b1;
                end
            endcase
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_sram_clr.sv
// Self-checking bench for sram_clr (DATA_W=8, ADDR_W=3): vector tables plus
// hand sequences, with expected outputs queued as stimulus is driven.
module tb_sram_clr;

`ifdef SRAM_CLR_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       we = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] din = 8'h00;
    logic       clr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic       en;
        logic       we;
        logic [2:0] addr;
        logic [7:0] din;
        logic       clr;
        logic       exp_busy;
        logic       exp_valid;
        logic       chk_dout;
        logic [7:0] exp_dout;
        string      name;
    } vec_t;

    typedef struct {
        logic       busy;
        logic       valid;
        logic       chk;
        logic [7:0] dout;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    sram_clr #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .din(din),
        .clr(clr), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic w, input logic [2:0] a,
                                input logic [7:0] d, input logic c, input logic eb,
                                input logic ev, input logic ck, input logic [7:0] ed,
                                input string n);
        vec_t v;
        v.en = e; v.we = w; v.addr = a; v.din = d; v.clr = c;
        v.exp_busy = eb; v.exp_valid = ev; v.chk_dout = ck; v.exp_dout = ed; v.name = n;
        return v;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", n, act, exp);
    endtask

    // Drive one vector at the falling edge, compare after the next rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        en = v.en; we = v.we; addr = v.addr; din = v.din; clr = v.clr;
        sb.push_back('{v.exp_busy, v.exp_valid, v.chk_dout, v.exp_dout, v.name});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", v.name);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
            chk({e.name, ".valid"}, {7'd0, dout_valid}, {7'd0, e.valid});
            if (e.chk) chk({e.name, ".dout"}, dout, e.dout);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    // After rst release or a sampled clr: busy for exactly 8 edges, dout held.
    task automatic busy_walk(input string n, input logic [7:0] held);
        for (int k = 1; k <= 8; k++)
            apply(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, (k < 8), 1'b0, 1'b1, held, n));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset.dout", dout, 8'h00);
        chk("reset.valid", {7'd0, dout_valid}, 8'h00);
        chk("reset.busy", {7'd0, busy}, 8'h01);
        rst = 1'b0;
        busy_walk("rst_walk", 8'h00);

        // Reads of a freshly cleared array, then write/read and read-during-write.
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(1'b1, 1'b0, 3'(a), 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "init_rd"));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, WF ? 8'hA5 : 8'h00, "wr3"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, "rd3"));
        tbl.push_back(mk(1'b1, 1'b1, 3'd5, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, WF ? 8'h11 : 8'h00, "wr5a"));
        tbl.push_back(mk(1'b1, 1'b1, 3'd5, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, WF ? 8'h22 : 8'h11, "rdw5"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, "rd5"));
        run_tbl();

        // Fill with 0xFF, then clr together with an access.
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(1'b1, 1'b1, 3'(a), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "fill"));
        tbl.push_back(mk(1'b1, 1'b1, 3'd0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, WF ? 8'hFF : 8'h00, "clr_drop"));
        run_tbl();
        for (int k = 1; k <= 8; k++) begin
            if (k == 3)
                apply(mk(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, WF ? 8'hFF : 8'h00, "busy_wr"));
            else if (k == 5)
                apply(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, WF ? 8'hFF : 8'h00, "busy_clr"));
            else
                apply(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, (k < 8), 1'b0, 1'b1, WF ? 8'hFF : 8'h00, "clr_walk"));
        end
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(1'b1, 1'b0, 3'(a), 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "post_clr_rd"));
        run_tbl();

        // Reset in the 4th clear cycle.
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "wr1"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, "rd1"));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C, "clr2"));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, "clr2_walk"));
        run_tbl();
        rst = 1'b1;
        #1;
        chk("midrst.dout", dout, 8'h00);
        chk("midrst.valid", {7'd0, dout_valid}, 8'h00);
        chk("midrst.busy", {7'd0, busy}, 8'h01);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_walk("rst2_walk", 8'h00);

        // Top address, then address 0, then hold with en=0.
        tbl.push_back(mk(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "rd1_cleared"));
        tbl.push_back(mk(1'b1, 1'b1, 3'd7, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, WF ? 8'h7E : 8'h00, "wr7"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, "rd7"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, "rd0"));
        tbl.push_back(mk(1'b0, 1'b0, 3'd7, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "hold"));
        tbl.push_back(mk(1'b0, 1'b1, 3'd7, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "hold2"));
        tbl.push_back(mk(1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, "rd7_again"));
        run_tbl();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
